// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// counter_ctrl_pkg : shared mode codes, FSM encoding and helpers for the
//                    counter job arbiter.   rev 1.0
// ============================================================================
package counter_ctrl_pkg;

  localparam int LEN_W_DEF = 4;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_DN3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic en);
    return (en && (v != 4'hF)) ? v + 4'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-way round-robin picker; pointer moves to the loser of the
//               finished job on each advance strobe.   rev 1.0
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       adv_winner,
  output logic       winner,
  output logic       any
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~adv_winner;
    end
  end

  // Pointer only matters on a tie; otherwise the lone requester wins.
  assign winner = (req == 2'b11) ? ptr : req[1];
  assign any    = |req;

endmodule
`default_nettype wire

// File: rtl/counter_job_arbiter.sv
`default_nettype none
// ============================================================================
// counter_job_arbiter : shares one 4-bit mode counter between two job
//                       requesters (load, run len cycles, report).   rev 1.0
// ============================================================================
module counter_job_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       mode0,
  input  logic [1:0]       mode1,
  input  logic [3:0]       D0,
  input  logic [3:0]       D1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic [3:0]       result_Q,
  output logic [3:0]       rco_count,
  output logic             err,
  output logic             cnt_enable,
  output logic [1:0]       cnt_mode,
  output logic [3:0]       cnt_D,
  input  logic [3:0]       cnt_Q,
  input  logic             cnt_rco,
  input  logic             cnt_load
);

  state_t           state, next_state;
  logic             owner, next_owner, owner_req, advance;
  logic             arb_winner, arb_any;
  logic [1:0]       job_mode, sel_mode;
  logic [3:0]       sel_d;
  logic [LEN_W-1:0] job_len, sel_len, len_cnt;
  logic [3:0]       rco_acc;
  logic             chk_pending, err_r;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({req1, req0}),
    .advance    (advance),
    .adv_winner (owner),
    .winner     (arb_winner),
    .any        (arb_any)
  );

  assign sel_mode  = arb_winner ? mode1 : mode0;
  assign sel_d     = arb_winner ? D1    : D0;
  assign sel_len   = arb_winner ? len1  : len0;
  assign owner_req = owner ? req1 : req0;

  always_comb begin
    next_state = state;
    next_owner = owner;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_any) begin
          next_state = S_LOAD;
          next_owner = arb_winner;
        end
      end
      S_LOAD: begin
        if (!owner_req) begin
          next_state = S_IDLE;
          advance    = 1'b1;
        end else if (job_len == '0) begin
          next_state = S_DONE;
        end else begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          next_state = S_IDLE;
          advance    = 1'b1;
        end else if (len_cnt == LEN_W'(1)) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
        advance    = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      job_mode    <= MODE_UP;
      job_len     <= '0;
      len_cnt     <= '0;
      rco_acc     <= 4'd0;
      chk_pending <= 1'b0;
      err_r       <= 1'b0;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      result_Q    <= 4'd0;
      rco_count   <= 4'd0;
      cnt_enable  <= 1'b0;
      cnt_mode    <= MODE_UP;
      cnt_D       <= 4'd0;
    end else begin
      state       <= next_state;
      owner       <= next_owner;
      chk_pending <= (state == S_LOAD);

      if (state == S_IDLE && arb_any) begin
        job_mode <= sel_mode;
        job_len  <= sel_len;
        cnt_D    <= sel_d;
      end

      if (state == S_LOAD) begin
        len_cnt <= job_len;
      end else if (state == S_RUN) begin
        len_cnt <= len_cnt - LEN_W'(1);
      end

      if (state == S_IDLE) begin
        rco_acc <= 4'd0;
        err_r   <= (sel_mode == MODE_LOAD);
      end else begin
        if (state == S_RUN) begin
          rco_acc <= sat_inc4(rco_acc, cnt_rco);
        end
        if (chk_pending && !cnt_load) begin
          err_r <= 1'b1;
        end
      end

      // The DONE-cycle rco still belongs to the job, so fold it in here.
      if (state == S_DONE) begin
        result_Q  <= cnt_Q;
        rco_count <= sat_inc4(rco_acc, cnt_rco);
      end

      grant0     <= (next_state != S_IDLE) && !next_owner;
      grant1     <= (next_state != S_IDLE) &&  next_owner;
      done0      <= (next_state == S_DONE) && !next_owner;
      done1      <= (next_state == S_DONE) &&  next_owner;
      cnt_enable <= (next_state == S_LOAD) ||
                    ((next_state == S_RUN) && (job_mode != MODE_LOAD));
      if (next_state == S_LOAD) begin
        cnt_mode <= MODE_LOAD;
      end else if (next_state == S_RUN && job_mode != MODE_LOAD) begin
        cnt_mode <= job_mode;
      end else begin
        cnt_mode <= MODE_UP;
      end
    end
  end

  // A zero-length job reaches DONE in the load-check cycle, so cnt_load is
  // folded in directly there instead of through err_r.
  assign err = (state == S_DONE) && (err_r || (chk_pending && !cnt_load));

endmodule
`default_nettype wire

// File: tb/tb_counter_job_arbiter.sv
`default_nettype none
// ============================================================================
// tb_counter_job_arbiter : scoreboard bench with a 4-bit mode counter stub.
// ============================================================================
module tb_counter_job_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] mode0 = 2'd0, mode1 = 2'd0;
  logic [3:0] D0 = 4'd0, D1 = 4'd0, len0 = 4'd0, len1 = 4'd0;
  logic       grant0, grant1, done0, done1, err, cnt_enable;
  logic [3:0] result_Q, rco_count, cnt_D;
  logic [1:0] cnt_mode;
  logic [3:0] cnt_Q = 4'd0;
  logic       cnt_rco = 1'b0, cnt_load = 1'b0, no_load = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       owner;
    logic [3:0] q;
    logic [3:0] rc;
    logic       err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] last_q = 4'd0;

  always #5 clk = ~clk;

  counter_job_arbiter #(.LEN_W(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .mode0(mode0), .mode1(mode1), .D0(D0), .D1(D1), .len0(len0), .len1(len1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .result_Q(result_Q), .rco_count(rco_count), .err(err),
    .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_D(cnt_D),
    .cnt_Q(cnt_Q), .cnt_rco(cnt_rco), .cnt_load(cnt_load)
  );

  // Counter stub: 11 loads, 00 up, 01 down, 10 down by 3; rco/load registered.
  always @(posedge clk) begin
    cnt_rco  <= 1'b0;
    cnt_load <= 1'b0;
    if (cnt_enable) begin
      case (cnt_mode)
        2'b11: begin cnt_Q <= cnt_D; cnt_load <= !no_load; end
        2'b00: begin cnt_rco <= (cnt_Q == 4'hF); cnt_Q <= cnt_Q + 4'd1; end
        2'b01: begin cnt_rco <= (cnt_Q == 4'h0); cnt_Q <= cnt_Q - 4'd1; end
        default: begin cnt_rco <= (cnt_Q < 4'd3); cnt_Q <= cnt_Q - 4'd3; end
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic who, input logic [3:0] d, input logic [1:0] m,
                                 input int len, input logic nl);
    exp_t e;
    logic [3:0] q = d;
    int r = 0;
    logic wp = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (wp) r++;
      wp = 1'b0;
      case (m)
        2'b00: begin wp = (q == 4'hF); q = q + 4'd1; end
        2'b01: begin wp = (q == 4'h0); q = q - 4'd1; end
        2'b10: begin wp = (q < 4'd3);  q = q - 4'd3; end
        default: ;
      endcase
    end
    if (wp) r++;
    e.owner = who;
    e.q     = q;
    e.rc    = (r > 15) ? 4'hF : 4'(r);
    e.err   = (m == 2'b11) || nl;
    return e;
  endfunction

  // Done side of the scoreboard; result fields land one cycle after done.
  always @(negedge clk) begin
    if (!reset && (done0 || done1)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'(done1), 32'hDEAD);
      end else begin
        mon_e = sb.pop_front();
        check_eq("done_owner", 32'(done1), 32'(mon_e.owner));
        check_eq("err", 32'(err), 32'(mon_e.err));
        @(negedge clk);
        check_eq("result_Q", 32'(result_Q), 32'(mon_e.q));
        check_eq("rco_count", 32'(rco_count), 32'(mon_e.rc));
      end
    end
  end

  function automatic logic g_of(input logic who);
    return who ? grant1 : grant0;
  endfunction

  function automatic logic d_of(input logic who);
    return who ? done1 : done0;
  endfunction

  task automatic set_job(input logic who, input logic [3:0] d, input logic [1:0] m, input logic [3:0] len);
    if (who) begin D1 = d; mode1 = m; len1 = len; end
    else     begin D0 = d; mode0 = m; len0 = len; end
  endtask

  task automatic set_req(input logic who, input logic v);
    if (who) req1 = v; else req0 = v;
  endtask

  task automatic wait_grant(input logic who);
    int n = 0;
    @(negedge clk);
    while (!g_of(who) && n < 20) begin @(negedge clk); n++; end
    check_eq("grant_timeout", 32'(g_of(who)), 32'd1);
  endtask

  // Runs from a LOAD-cycle negedge to the done pulse, checking RUN drive.
  task automatic run_to_done(input logic who, input logic [1:0] m, input int len);
    int n = 0;
    @(negedge clk);
    n = 1;
    while (!d_of(who) && n < 40) begin
      check_eq("run_enable", 32'(cnt_enable), 32'(m != 2'b11));
      check_eq("run_mode_not_load", 32'(cnt_mode == 2'b11), 32'd0);
      @(negedge clk);
      n++;
    end
    check_eq("done_latency", 32'(n), 32'(len + 1));
  endtask

  task automatic run_job(input logic who, input logic [3:0] d, input logic [1:0] m,
                         input logic [3:0] len, input logic nl);
    exp_t e;
    no_load = nl;
    set_job(who, d, m, len);
    e = model(who, d, m, int'(len), nl);
    sb.push_back(e);
    last_q = e.q;
    set_req(who, 1'b1);
    wait_grant(who);
    check_eq("load_enable", 32'(cnt_enable), 32'd1);
    check_eq("load_mode", 32'(cnt_mode), 32'h3);
    check_eq("load_D", 32'(cnt_D), 32'(d));
    run_to_done(who, m, int'(len));
    set_req(who, 1'b0);
    @(negedge clk);
    @(negedge clk);
    no_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grants"}, 32'({grant1, grant0}), 32'd0);
    check_eq({tag, "_dones"},  32'({done1, done0}),   32'd0);
    check_eq({tag, "_cnt_enable"}, 32'(cnt_enable), 32'd0);
    check_eq({tag, "_err"},    32'(err), 32'd0);
    check_eq({tag, "_cnt_mode"}, 32'(cnt_mode), 32'd0);
    check_eq({tag, "_cnt_D"},  32'(cnt_D), 32'd0);
    check_eq({tag, "_result_Q"}, 32'(result_Q), 32'd0);
    check_eq({tag, "_rco_count"}, 32'(rco_count), 32'd0);
  endtask

  initial begin
    exp_t e;
    int n;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Up count through a wrap.
    run_job(1'b0, 4'hD, 2'b00, 4'd3, 1'b0);

    // Simultaneous requests straight after reset: req0 first, req1 at DONE+2.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_job(1'b0, 4'hD, 2'b00, 4'd3);
    set_job(1'b1, 4'h2, 2'b01, 4'd4);
    sb.push_back(model(1'b0, 4'hD, 2'b00, 3, 1'b0));
    e = model(1'b1, 4'h2, 2'b01, 4, 1'b0);
    sb.push_back(e);
    check_eq("tie_model_q", 32'(e.q), 32'hE);
    last_q = e.q;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    check_eq("tie_grant0", 32'({grant1, grant0}), 32'b01);
    run_to_done(1'b0, 2'b00, 3);
    req0 = 1'b0;
    @(negedge clk);
    check_eq("b2b_idle_gap", 32'(grant1), 32'd0);
    @(negedge clk);
    check_eq("b2b_grant1", 32'(grant1), 32'd1);
    run_to_done(1'b1, 2'b01, 4);
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Zero length, rejected mode, and a counter that never reports load.
    run_job(1'b1, 4'h7, 2'b00, 4'd0, 1'b0);
    run_job(1'b0, 4'h3, 2'b11, 4'd2, 1'b0);
    run_job(1'b1, 4'h5, 2'b00, 4'd2, 1'b1);

    // Owner abort in the second RUN cycle, with req1 waiting.
    set_job(1'b0, 4'h1, 2'b00, 4'd5);
    req0 = 1'b1;
    wait_grant(1'b0);
    set_job(1'b1, 4'h9, 2'b10, 4'd2);
    sb.push_back(model(1'b1, 4'h9, 2'b10, 2, 1'b0));
    req1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    check_eq("abort_enable", 32'(cnt_enable), 32'd0);
    check_eq("abort_grants", 32'({grant1, grant0}), 32'd0);
    check_eq("abort_no_done", 32'(done0), 32'd0);
    check_eq("abort_result_hold", 32'(result_Q), 32'(last_q));
    @(negedge clk);
    check_eq("abort_next_grant1", 32'(grant1), 32'd1);
    run_to_done(1'b1, 2'b10, 2);
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN.
    set_job(1'b0, 4'h4, 2'b00, 4'd6);
    req0 = 1'b1;
    wait_grant(1'b0);
    repeat (2) @(negedge clk);
    check_eq("pre_reset_running", 32'(cnt_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    req0 = 1'b0;
    reset = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(cnt_enable) + int'(done0);
    end
    check_eq("post_reset_quiet", 32'(n), 32'd0);

    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
